// File: rtl/bitwise_pkg.sv
// Shared constants for the bitwise arbiter slice:
// opcodes and FSM state encodings.
package bitwise_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/bitwise_core.sv
// Combinational WIDTH-bit bitwise unit.
// NOT inverts a and ignores b.
module bitwise_core
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    unique case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
    endcase
  end

endmodule

// File: rtl/bitwise_arbiter.sv
// Round-robin arbiter sharing one bitwise_core
// between two valid/ready requesters.
module bitwise_arbiter
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [1:0]       rsp_op,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  logic [1:0]       state;
  logic             last_grant;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] core_res;
  logic             idle;
  logic             gnt0;
  logic             gnt1;

  assign idle = (state == ST_IDLE);

  // On a tie, the requester not granted last time wins.
  assign gnt0 = req0_valid & (~req1_valid | last_grant);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = idle & gnt0;
  assign req1_ready = idle & gnt1;
  assign rsp_valid  = (state == ST_RESP);
  assign busy       = ~idle;

  bitwise_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (core_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_op     <= '0;
      rsp_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt0 | gnt1) begin
            op_q       <= gnt1 ? req1_op : req0_op;
            a_q        <= gnt1 ? req1_a : req0_a;
            b_q        <= gnt1 ? req1_b : req0_b;
            id_q       <= gnt1;
            last_grant <= gnt1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data <= core_res;
          rsp_op   <= op_q;
          rsp_id   <= id_q;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_arbiter.sv
// Directed, table-driven bench for bitwise_arbiter
// with hand sequences for stalls, resets and ties.
module tb_bitwise_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [1:0]   rsp_op;
  logic [W-1:0] rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

  bitwise_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_op     (rsp_op),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       sel;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic v,
                       input logic [1:0] op,
                       input logic [3:0] a,
                       input logic [3:0] b);
    if (sel) begin
      req1_valid = v; req1_op = op;
      req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op;
      req0_a = a; req0_b = b;
    end
  endtask

  task automatic wait_ready(input logic sel,
                            output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sel ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  initial begin
    bit ok;
    int nrsp;
    int seen0;
    logic [3:0] ids [4];
    logic [3:0] dat [4];

    vecs[0] = '{1'b0, 2'b00, 4'd12, 4'd5, 4'd4};
    vecs[1] = '{1'b1, 2'b01, 4'd12, 4'd5, 4'd13};
    vecs[2] = '{1'b1, 2'b10, 4'd12, 4'd5, 4'd9};
    vecs[3] = '{1'b1, 2'b11, 4'd12, 4'd5, 4'd3};
    vecs[4] = '{1'b1, 2'b10, 4'd3,  4'd3, 4'd0};
    vecs[5] = '{1'b1, 2'b00, 4'd0,  4'd1, 4'd0};
    vecs[6] = '{1'b0, 2'b11, 4'd0,  4'd7, 4'd15};
    vecs[7] = '{1'b0, 2'b01, 4'd10, 4'd5, 4'd15};

    rst = 1'b1;
    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_op", rsp_op, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst = 1'b0;

    // table-driven single-requester operations
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].sel, 1'b1, vecs[i].op,
            vecs[i].a, vecs[i].b);
      #1;
      wait_ready(vecs[i].sel, ok);
      check($sformatf("v%0d_accept", i), ok, 1);
      check($sformatf("v%0d_other_rdy", i),
            vecs[i].sel ? req0_ready : req1_ready, 0);
      @(negedge clk);
      drive(vecs[i].sel, 1'b0, 2'b00, 4'd0, 4'd0);
      #1;
      check($sformatf("v%0d_n1_valid", i), rsp_valid, 0);
      check($sformatf("v%0d_n1_busy", i), busy, 1);
      @(negedge clk); #1;
      check($sformatf("v%0d_n2_valid", i), rsp_valid, 1);
      check($sformatf("v%0d_data", i), rsp_data,
            vecs[i].exp);
      check($sformatf("v%0d_id", i), rsp_id, vecs[i].sel);
      check($sformatf("v%0d_op", i), rsp_op, vecs[i].op);
    end

    // backpressure: hold RESP for 5 cycles
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 2'b00, 4'd12, 4'd5);
    #1;
    wait_ready(1'b0, ok);
    check("bp_accept", ok, 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
    drive(1'b1, 1'b1, 2'b10, 4'd12, 4'd5);
    #1;
    check("bp_exec_r1rdy", req1_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check($sformatf("bp%0d_valid", i), rsp_valid, 1);
      check($sformatf("bp%0d_data", i), rsp_data, 4);
      check($sformatf("bp%0d_id", i), rsp_id, 0);
      check($sformatf("bp%0d_r1rdy", i), req1_ready, 0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_r1rdy", req1_ready, 0);
    @(negedge clk); #1;
    check("bp_idle_valid", rsp_valid, 0);
    check("bp_idle_r1rdy", req1_ready, 1);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
    #1;
    check("bp_r1_n1_valid", rsp_valid, 0);
    @(negedge clk); #1;
    check("bp_r1_valid", rsp_valid, 1);
    check("bp_r1_data", rsp_data, 9);
    check("bp_r1_id", rsp_id, 1);

    // late drop: req0 pulses once while busy
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 4'd12, 4'd5);
    #1;
    wait_ready(1'b1, ok);
    check("ld_accept", ok, 1);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
    drive(1'b0, 1'b1, 2'b01, 4'd1, 4'd2);
    #1;
    check("ld_pulse_rdy", req0_ready, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
    #1;
    nrsp = 0;
    seen0 = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) nrsp++;
      if (req0_ready) seen0++;
      @(negedge clk); #1;
    end
    check("ld_rsp_count", nrsp, 1);
    check("ld_r0_ready", seen0, 0);

    // reset while in EXEC
    drive(1'b0, 1'b1, 2'b00, 4'd12, 4'd5);
    #1;
    wait_ready(1'b0, ok);
    check("rm_accept", ok, 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rm_valid", rsp_valid, 0);
    check("rm_busy", busy, 0);
    check("rm_data", rsp_data, 0);
    nrsp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) nrsp++;
    end
    check("rm_no_rsp", nrsp, 0);

    // tie: both valid continuously after reset
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b01, 4'd3, 4'd3);
    drive(1'b1, 1'b1, 2'b10, 4'd0, 4'd1);
    #1;
    check("tie_first_r0", req0_ready, 1);
    nrsp = 0;
    seen0 = 0;
    for (int i = 0; i < 40 && nrsp < 4; i++) begin
      if (req0_ready && req1_ready) seen0++;
      if (rsp_valid) begin
        ids[nrsp] = {3'b0, rsp_id};
        dat[nrsp] = rsp_data;
        nrsp++;
      end
      @(negedge clk); #1;
    end
    check("tie_rsp_count", nrsp, 4);
    check("tie_both_ready", seen0, 0);
    for (int k = 0; k < 4; k++) begin
      if (k < nrsp) begin
        check($sformatf("tie%0d_id", k), ids[k], k % 2);
        check($sformatf("tie%0d_data", k), dat[k],
              (k % 2) ? 1 : 3);
      end
    end
    drive(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 2'b00, 4'd0, 4'd0);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bitwise_arbiter.md
# bitwise_arbiter

Shares one WIDTH-bit bitwise unit (AND/OR/XOR/NOT) between two requesters. Round-robin arbitration, valid/ready handshakes on both request ports and the response port. Holds each result until the consumer accepts it. Sits between operand sources (e.g. a test sequencer or register file) and the combinational bitwise datapath, so neither requester can starve or corrupt the other's operation.

## Interface
Parameters:
- WIDTH, 4, operand/result width in bits

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 presents an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  2  opcode: 00 AND, 01 OR, 10 XOR, 11 NOT (~a, b ignored)
- req0_a  in  WIDTH  operand a
- req0_b  in  WIDTH  operand b
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that issued the result
- rsp_op  out  2  opcode of the result
- rsp_data  out  WIDTH  result
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states:
  - IDLE: if any reqN_valid, grant one requester. Assert its reqN_ready combinationally this cycle, latch op/a/b/id, go to EXEC.
  - EXEC: latch the datapath output into rsp_data, go to RESP.
  - RESP: rsp_valid=1. On rsp_ready go to IDLE, otherwise hold all rsp_* stable.
- Arbitration:
  - Only one request valid: grant it.
  - Both valid: grant the one not in last_grant.
  - last_grant updates only on accept (valid&ready).
  - Reset value of last_grant = 1, so requester 0 wins the first tie.
- reqN_ready is asserted only in IDLE and only for the granted requester. It is never asserted for both requesters in the same cycle.
- Requesters hold op/a/b stable while valid && !ready. The arbiter samples them only on the accept cycle.
- NOT: rsp_data = ~a. Operand b is ignored.
- All results are exactly WIDTH bits; there is no carry or extension.
- rsp_ready is ignored outside RESP.

## Timing
- Reset values:
  - state=IDLE, last_grant=1
  - rsp_valid=0, rsp_id=0, rsp_op=0, rsp_data=0
  - busy=0, req0_ready=0, req1_ready=0
- Latency: accept at cycle N, rsp_valid=1 at cycle N+2.
- With rsp_ready held high, the next accept can happen at N+3, so peak throughput is 1 op / 3 cycles.
- rsp_ready low stalls in RESP indefinitely. Requests stay pending (ready=0) and none are dropped.
- Back-to-back tie with both valid continuously: grants alternate 0,1,0,1...
- Single requester valid continuously: it receives every slot.
- A new request arriving in the same cycle the response is accepted in RESP is not granted that cycle. It is granted in the following IDLE cycle.
- rst asserted mid-operation (EXEC or RESP): the in-flight op is discarded. The next cycle shows reset values and no response is emitted for it.
- reqN_valid dropping before accept is legal; no grant is issued for it.

## Structure
- Shared package/header bitwise_pkg holds:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11
  - FSM state encodings ST_IDLE, ST_EXEC, ST_RESP
- One sub-module, bitwise_core: purely combinational, inputs op/a/b, output result; WIDTH parameter passed through.
- Arbiter, FSM and response registers live in bitwise_arbiter.

## Test plan
- Reset then single op: req0 op=AND a=12 b=5 → req0_ready at accept cycle N; rsp_valid at N+2 with rsp_data=4, rsp_id=0, rsp_op=00.
- Opcode sweep on req1 with a=12 b=5: OR → 13, XOR → 9, NOT → 3. Also a=3 b=3 XOR → 0, and a=0 b=1 AND → 0.
- Tie fairness: both valid continuously (req0 OR 3|3, req1 XOR 0^1), rsp_ready=1 → rsp_id sequence 0,1,0,1, data 3,1,3,1.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid/rsp_data/rsp_id held stable; req ready stays 0; no lost or duplicated response after rsp_ready rises.
- Reset mid-op: rst in EXEC → next cycle rsp_valid=0, busy=0, state IDLE. The first tie after reset is granted to requester 0.
- Late-drop: req0_valid pulsed for 1 cycle while busy → never accepted, no response produced.
